// File: rtl/seq_serializer.sv
// seq_serializer: accepts DATA_W-bit words over valid/ready and shifts them out one bit per clock on seq.
// Define SEQ_SERIALIZER_PARITY_EN to append an even-parity bit after every word.
module seq_serializer #(
    parameter int DATA_W    = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              seq,
    output logic              seq_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

`ifdef SEQ_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t            state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n, shifted;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              seq_n, seq_valid_n, frame_done_n;
    logic              accept, last_bit, first_bit;
`ifdef SEQ_SERIALIZER_PARITY_EN
    logic              parity, parity_n;
`endif

    assign last_bit  = (state == SHIFT) && (cnt == LAST);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign shifted   = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
    assign first_bit = (LSB_FIRST != 0) ? in_data[0] : in_data[DATA_W-1];

    // The slot that may accept the next word is the final cycle of the current frame.
    always_comb begin
`ifdef SEQ_SERIALIZER_PARITY_EN
        in_ready = (state == IDLE) || (state == PARITY);
`else
        in_ready = (state == IDLE) || last_bit;
`endif
    end

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        cnt_n        = cnt;
        seq_n        = 1'b0;
        seq_valid_n  = 1'b0;
        frame_done_n = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
        parity_n     = parity;
`endif
        if (accept) begin
            // A reload puts the first bit straight onto seq, so streams have no bubble.
            state_n     = SHIFT;
            shreg_n     = in_data;
            cnt_n       = '0;
            seq_n       = first_bit;
            seq_valid_n = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
            parity_n    = ^in_data;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (last_bit) begin
                        cnt_n = '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
                        state_n      = PARITY;
                        seq_n        = parity;
                        seq_valid_n  = 1'b1;
                        frame_done_n = 1'b1;
`else
                        state_n = IDLE;
`endif
                    end else begin
                        shreg_n     = shifted;
                        cnt_n       = cnt + CNT_W'(1);
                        seq_n       = (LSB_FIRST != 0) ? shifted[0] : shifted[DATA_W-1];
                        seq_valid_n = 1'b1;
`ifndef SEQ_SERIALIZER_PARITY_EN
                        frame_done_n = ((cnt + CNT_W'(1)) == LAST);
`endif
                    end
                end
`ifdef SEQ_SERIALIZER_PARITY_EN
                PARITY: state_n = IDLE;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            seq        <= 1'b0;
            seq_valid  <= 1'b0;
            frame_done <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            seq        <= seq_n;
            seq_valid  <= seq_valid_n;
            frame_done <= frame_done_n;
`ifdef SEQ_SERIALIZER_PARITY_EN
            parity     <= parity_n;
`endif
        end
    end

endmodule
